// File: rtl/note_sequencer_pkg.sv
// audio_seq_pkg: shared types and defaults for the note sequencer.
//   seq_state_t : RAM-access FSM state encoding
//   NOTE_REST   : note word value meaning "silence, no trigger"
//   SEQ_ADDR_W  : default step address width (16 steps)
//   SEQ_DATA_W  : default note word width (Hz)
package audio_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_LOAD
    } seq_state_t;

    localparam int NOTE_REST  = 0;
    localparam int SEQ_ADDR_W = 4;
    localparam int SEQ_DATA_W = 16;

endpackage

// File: rtl/note_sequencer_if.sv
// note_sequencer_if: edit write channel into the note RAM.
//   wr_req  : request, held until wr_ack
//   wr_addr : step to overwrite, stable while wr_req is high
//   wr_data : new note word, stable while wr_req is high
//   wr_ack  : one-cycle pulse coincident with the RAM write
// master = editor side, slave = sequencer side.
interface note_sequencer_if
    import audio_seq_pkg::*;
#(
    parameter int ADDR_W = SEQ_ADDR_W,
    parameter int DATA_W = SEQ_DATA_W
);
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;

    modport master (output wr_req, output wr_addr, output wr_data, input wr_ack);
    modport slave  (input wr_req, input wr_addr, input wr_data, output wr_ack);
endinterface

// File: rtl/note_sequencer.sv
// note_sequencer: steps through a single-port note RAM on each tempo tick and
// drives freq/note_start, sharing the RAM port with an edit write channel.
//   sys_clk, reset : clock, asynchronous active-high reset
//   run            : playback enable (level)
//   step_tick      : one-cycle tempo pulse
//   length         : index of last step, sequence loops 0..length
//   wr             : edit write channel (slave side)
//   ram_*          : RAM port (address, write enable, write data, read data)
//   freq           : current note frequency, 0 during a rest
//   note_start     : one-cycle envelope trigger
//   step_idx       : index of the step last loaded
//   busy           : FSM not idle
//   overrun        : sticky, a tick was dropped
module note_sequencer
    import audio_seq_pkg::*;
#(
    parameter int ADDR_W = SEQ_ADDR_W,
    parameter int DATA_W = SEQ_DATA_W,
    parameter int RD_LAT = 2
)(
    input  logic              sys_clk,
    input  logic              reset,
    input  logic              run,
    input  logic              step_tick,
    input  logic [ADDR_W-1:0] length,
    note_sequencer_if.slave   wr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wren,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] freq,
    output logic              note_start,
    output logic [ADDR_W-1:0] step_idx,
    output logic              busy,
    output logic              overrun
);

    localparam logic [1:0] RD_LAST = 2'(RD_LAT - 1);

    seq_state_t        state_q, state_d;
    logic [1:0]        rd_cnt_q, rd_cnt_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              tick_pend_q, tick_pend_d;
    logic              overrun_q, overrun_d;
    logic [DATA_W-1:0] note_q, note_d;
    logic [DATA_W-1:0] freq_q, freq_d;
    logic              note_start_q, note_start_d;
    logic [ADDR_W-1:0] step_idx_q, step_idx_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              ram_wren_q, ram_wren_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              wr_ack_q, wr_ack_d;
    logic              busy_q, busy_d;
    logic              tick;

    assign tick = run & step_tick;

    always_comb begin
        state_d      = state_q;
        rd_cnt_d     = rd_cnt_q;
        ptr_d        = ptr_q;
        tick_pend_d  = tick_pend_q;
        overrun_d    = overrun_q;
        note_d       = note_q;
        freq_d       = freq_q;
        note_start_d = 1'b0;
        step_idx_d   = step_idx_q;
        ram_addr_d   = ram_addr_q;
        ram_wren_d   = 1'b0;
        ram_wdata_d  = ram_wdata_q;
        wr_ack_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // A tick arriving in this very cycle counts as pending, so a
                // tick and a write request first seen together read first.
                if (tick_pend_q || tick) begin
                    state_d     = ST_READ;
                    rd_cnt_d    = '0;
                    ram_addr_d  = ptr_q;
                    tick_pend_d = 1'b0;
                    if (tick_pend_q && tick) overrun_d = 1'b1;
                end else if (wr.wr_req) begin
                    state_d     = ST_WRITE;
                    ram_wren_d  = 1'b1;
                    ram_addr_d  = wr.wr_addr;
                    ram_wdata_d = wr.wr_data;
                    wr_ack_d    = 1'b1;
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
                if (tick) begin
                    if (tick_pend_q) overrun_d = 1'b1;
                    else             tick_pend_d = 1'b1;
                end
            end
            ST_READ: begin
                if (tick) overrun_d = 1'b1;
                if (rd_cnt_q == RD_LAST) begin
                    note_d  = ram_rdata;
                    state_d = ST_LOAD;
                end else begin
                    rd_cnt_d = rd_cnt_q + 2'd1;
                end
            end
            ST_LOAD: begin
                if (tick) overrun_d = 1'b1;
                step_idx_d = ptr_q;
                if (note_q != DATA_W'(NOTE_REST)) begin
                    freq_d       = note_q;
                    note_start_d = 1'b1;
                end else begin
                    freq_d = '0;
                end
                // >= rather than == so a shortened loop wraps immediately.
                ptr_d   = (ptr_q >= length) ? '0 : ptr_q + 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Stopping playback rewinds and forgets ticks; an in-flight read
        // still completes but cannot move the pointer.
        if (!run) begin
            tick_pend_d = 1'b0;
            overrun_d   = 1'b0;
            ptr_d       = '0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            rd_cnt_q     <= '0;
            ptr_q        <= '0;
            tick_pend_q  <= 1'b0;
            overrun_q    <= 1'b0;
            note_q       <= '0;
            freq_q       <= '0;
            note_start_q <= 1'b0;
            step_idx_q   <= '0;
            ram_addr_q   <= '0;
            ram_wren_q   <= 1'b0;
            ram_wdata_q  <= '0;
            wr_ack_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_cnt_q     <= rd_cnt_d;
            ptr_q        <= ptr_d;
            tick_pend_q  <= tick_pend_d;
            overrun_q    <= overrun_d;
            note_q       <= note_d;
            freq_q       <= freq_d;
            note_start_q <= note_start_d;
            step_idx_q   <= step_idx_d;
            ram_addr_q   <= ram_addr_d;
            ram_wren_q   <= ram_wren_d;
            ram_wdata_q  <= ram_wdata_d;
            wr_ack_q     <= wr_ack_d;
            busy_q       <= busy_d;
        end
    end

    assign ram_addr   = ram_addr_q;
    assign ram_wren   = ram_wren_q;
    assign ram_wdata  = ram_wdata_q;
    assign wr.wr_ack  = wr_ack_q;
    assign freq       = freq_q;
    assign note_start = note_start_q;
    assign step_idx   = step_idx_q;
    assign busy       = busy_q;
    assign overrun    = overrun_q;

endmodule

// File: doc/note_sequencer.md
# note_sequencer

Playback controller for the note RAM: it steps through a 16-entry single-port RAM of note frequencies on each tempo tick and drives `freq`/`note_start` into the tone generator and envelope monostable. It shares the single RAM port between playback reads and an edit write port, which replaces the ad-hoc phased read/modify/write loop. It runs on the 50 MHz system clock, with all RAM access sequenced by one FSM.

## Interface
- `ADDR_W`, 4, RAM address width (16 steps)
- `DATA_W`, 16, note word width (frequency in Hz; 0 = rest)
- `RD_LAT`, 2, RAM read latency in cycles (address edge to valid `ram_rdata`), range 1..3
- `sys_clk` in 1: system clock
- `reset` in 1: asynchronous, active-high reset
- `run` in 1: level, playback enable
- `step_tick` in 1: one-cycle tempo pulse
- `length` in ADDR_W: index of last step; the sequence loops 0..length
- `wr_req` in 1: edit write request, held until `wr_ack`
- `wr_addr` in ADDR_W: edit address, stable while `wr_req` is high
- `wr_data` in DATA_W: edit data, stable while `wr_req` is high
- `wr_ack` out 1: one-cycle pulse, coincident with the RAM write
- `ram_addr` out ADDR_W: RAM address
- `ram_wren` out 1: RAM write enable
- `ram_wdata` out DATA_W: RAM write data
- `ram_rdata` in DATA_W: RAM read data
- `freq` out DATA_W: current note frequency
- `note_start` out 1: one-cycle trigger for the envelope
- `step_idx` out ADDR_W: index of the step last loaded
- `busy` out 1: FSM not in IDLE
- `overrun` out 1: sticky flag, a tick was dropped

## Operation
- FSM states: IDLE, WRITE, READ (counts RD_LAT cycles), LOAD.
- Tick capture:
  - With `run`=1, `step_tick` sets `tick_pend`.
  - A tick that arrives while `tick_pend` is set, or while the FSM is in READ or LOAD, sets `overrun` and is dropped.
  - With `run`=0, ticks are ignored, `tick_pend` and `overrun` are cleared, and `ptr` is forced to 0.
- IDLE arbitration, playback first:
  - `tick_pend` set → READ. Clear `tick_pend`; `ram_addr`=`ptr`.
  - Otherwise, `wr_req` high → WRITE.
  - A write that loses to a read is served on the next IDLE cycle. It is never lost.
- WRITE, one cycle:
  - `ram_wren`=1, `ram_addr`=`wr_addr`, `ram_wdata`=`wr_data`, `wr_ack`=1.
  - Then → IDLE. The requester must drive `wr_req` low in the cycle after `wr_ack`.
- READ:
  - `ram_addr` is held at `ptr` for RD_LAT cycles.
  - On the last cycle, `ram_rdata` is registered into `note_q` → LOAD.
- LOAD, one cycle:
  - `step_idx`←`ptr`.
  - If `note_q`≠0: `freq`←`note_q` and `note_start` pulses.
  - If `note_q`=0 (rest): `freq`←0 and there is no `note_start`.
  - `ptr`←0 if `ptr`≥`length`, else `ptr`+1. This also wraps when `length` is lowered below `ptr`.
  - Then → IDLE.
- A write to the step currently being read is legal. It lands after the read and takes effect on the next loop.
- Widths: `ptr` is ADDR_W bits with explicit wrap as above. It never relies on natural overflow unless `length` = 2^ADDR_W−1.

## Timing
- Reset values: `freq`=0, `note_start`=0, `step_idx`=0, `ram_addr`=0, `ram_wren`=0, `ram_wdata`=0, `wr_ack`=0, `busy`=0, `overrun`=0, `ptr`=0, `tick_pend`=0, state IDLE.
- Reset mid-write deasserts `ram_wren` asynchronously. No partial `wr_ack` is issued.
- Tick to note, with the FSM idle and `tick_pend` sampled at edge E0:
  - READ runs from E0.
  - `note_q` is captured at edge E0+RD_LAT.
  - `freq`/`note_start` are valid after E0+RD_LAT+1.
  - For RD_LAT=2, `note_start` is high 3 cycles after the tick cycle.
- Write latency, `wr_req` seen at an idle edge: `wr_ack`/`ram_wren` go high for the following cycle.
- Worst-case wait for a write: RD_LAT+2 cycles.
- All outputs are registered. `note_start` and `wr_ack` are exactly one cycle wide.
- A tick and `wr_req` first high in the same cycle: the read is served first and the write immediately after LOAD.

## Structure
- Package `audio_seq_pkg`:
  - FSM state enum `seq_state_t`
  - `NOTE_REST` = 0
  - default widths `SEQ_ADDR_W`=4, `SEQ_DATA_W`=16
- Single module. Tick capture, arbitration and pointer logic are all inline; no sub-module is warranted.

## Test plan
- Reset, then `length`=2, RAM = {700, 882, 1049, 0…}, `run`=1, three ticks 100 cycles apart → `freq` = 700, 882, 1049, with a `note_start` each time. A fourth tick → `freq`=700 (wrap), `step_idx`=0.
- Step 1 holds 0, tick on that step → `freq`=0, `step_idx`=1, no `note_start`.
- `wr_req` (addr 5, data 440) in the same cycle as a tick → the read of `ptr` completes first. Then `ram_wren` and `wr_ack` pulse once, with `ram_addr`=5 and `ram_wdata`=440.
- A second tick 1 cycle after the first → `overrun`=1 and only one `note_start`. Driving `run`=0 clears `overrun`.
- `ptr`=7, then `length` changed to 3, then tick → step 7 plays and `ptr`←0. The next tick plays step 0.
- `reset` asserted during WRITE → `ram_wren` drops immediately, no `wr_ack`, all outputs at reset values.
